// File: rtl/instr_loader.sv
// Program loader: assembles MSB-first UART bytes into instruction words
// and writes them to consecutive instruction-memory addresses until HALT.
module instr_loader #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_BYTE = 8,
  parameter int unsigned NB_ADDR = 8,
  parameter int unsigned NB_OPCODE = 6,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE = 6'b111111
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 start_i,
  input  logic [NB_BYTE-1:0]   rx_data_i,
  input  logic                 rx_valid_i,
  output logic                 wr_en_o,
  output logic [NB_ADDR-1:0]   wr_addr_o,
  output logic [NB_DATA-1:0]   wr_data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [NB_ADDR:0]     word_count_o
);

  localparam int unsigned NB_BYTES = NB_DATA / NB_BYTE;
  localparam int unsigned NB_CNT = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam int unsigned NB_SHIFT = NB_DATA - NB_BYTE;
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t              state;
  logic [NB_CNT-1:0]   byte_cnt;
  logic [NB_SHIFT-1:0] shift;
  logic [NB_ADDR-1:0]  next_addr;

  logic is_halt;
  logic is_last_addr;

  assign is_halt = wr_data_o[NB_DATA-1 -: NB_OPCODE] == HALT_OPCODE;
  assign is_last_addr = &wr_addr_o;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      shift        <= '0;
      next_addr    <= '0;
      wr_en_o      <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      word_count_o <= '0;
    end else begin
      wr_en_o <= 1'b0;
      unique case (state)
        IDLE, DONE, ERROR: begin
          if (start_i) begin
            state        <= RECV;
            byte_cnt     <= '0;
            next_addr    <= '0;
            word_count_o <= '0;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
            busy_o       <= 1'b1;
          end
        end
        RECV: begin
          if (rx_valid_i) begin
            shift <= {shift[NB_SHIFT-NB_BYTE-1:0], rx_data_i};
            if (byte_cnt == CNT_LAST) begin
              byte_cnt  <= '0;
              wr_data_o <= {shift, rx_data_i};
              wr_addr_o <= next_addr;
              wr_en_o   <= 1'b1;
              state     <= WRITE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          word_count_o <= word_count_o + 1'b1;
          if (is_halt) begin
            state  <= DONE;
            done_o <= 1'b1;
            busy_o <= 1'b0;
          end else if (is_last_addr) begin
            state   <= ERROR;
            error_o <= 1'b1;
            busy_o  <= 1'b0;
          end else begin
            next_addr <= next_addr + 1'b1;
            state     <= RECV;
            // A strobe here becomes byte 0 of the next word
            if (rx_valid_i) begin
              shift    <= {shift[NB_SHIFT-NB_BYTE-1:0], rx_data_i};
              byte_cnt <= NB_CNT'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader (default and NB_ADDR=2).
module tb_instr_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start1 = 1'b0;
  logic [7:0]  rx1 = '0;
  logic        rv1 = 1'b0;
  logic        we1;
  logic [7:0]  wa1;
  logic [31:0] wd1;
  logic        busy1, done1, err1;
  logic [8:0]  wc1;

  logic        start2 = 1'b0;
  logic [7:0]  rx2 = '0;
  logic        rv2 = 1'b0;
  logic        we2;
  logic [1:0]  wa2;
  logic [31:0] wd2;
  logic        busy2, done2, err2;
  logic [2:0]  wc2;

  instr_loader u_dut (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start1),
    .rx_data_i(rx1), .rx_valid_i(rv1),
    .wr_en_o(we1), .wr_addr_o(wa1), .wr_data_o(wd1),
    .busy_o(busy1), .done_o(done1), .error_o(err1),
    .word_count_o(wc1)
  );

  instr_loader #(.NB_ADDR(2)) u_dut2 (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start2),
    .rx_data_i(rx2), .rx_valid_i(rv2),
    .wr_en_o(we2), .wr_addr_o(wa2), .wr_data_o(wd2),
    .busy_o(busy2), .done_o(done2), .error_o(err2),
    .word_count_o(wc2)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  q1a[$];
  logic [31:0] q1d[$];
  logic [1:0]  q2a[$];
  logic [31:0] q2d[$];

  always @(negedge clk) begin
    if (we1) begin q1a.push_back(wa1); q1d.push_back(wd1); end
    if (we2) begin q2a.push_back(wa2); q2d.push_back(wd2); end
  end

  task automatic pulse_start1();
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
  endtask

  task automatic pulse_start2();
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
  endtask

  // gap idle cycles after each byte; gap=0 keeps strobes back to back
  task automatic send_word1(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) begin
      rx1 = w[i*8 +: 8];
      rv1 = 1'b1;
      @(negedge clk);
      rv1 = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic send_word2(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) begin
      rx2 = w[i*8 +: 8];
      rv2 = 1'b1;
      @(negedge clk);
      rv2 = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_end1();
    for (int i = 0; i < 50; i++) begin
      if (done1 || err1) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_end2();
    for (int i = 0; i < 50; i++) begin
      if (done2 || err2) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({we1, busy1, done1, err1} !== 4'b0) begin
      n_err++; $display("FAIL reset_flags: got %b want 0000", {we1, busy1, done1, err1});
    end
    n_cmp++;
    if ({wa1, wd1, wc1} !== 49'h0) begin
      n_err++; $display("FAIL reset_regs: got %h want 0", {wa1, wd1, wc1});
    end
    rst_n = 1'b1;
    @(negedge clk);
    q1a.delete(); q1d.delete(); q2a.delete(); q2d.delete();
  endtask

  task automatic test_basic();
    pulse_start1();
    n_cmp++;
    if (busy1 !== 1'b1) begin
      n_err++; $display("FAIL basic_busy_after_start: got %b want 1", busy1);
    end
    send_word1(32'h20080005, 1);
    send_word1(32'hFC000000, 1);
    wait_end1();
    n_cmp++;
    if (q1a.size() !== 2) begin
      n_err++; $display("FAIL basic_nwrites: got %0d want 2", q1a.size());
    end else begin
      n_cmp++;
      if (q1a[0] !== 8'd0 || q1d[0] !== 32'h20080005) begin
        n_err++; $display("FAIL basic_w0: got %h@%h want 20080005@00", q1d[0], q1a[0]);
      end
      n_cmp++;
      if (q1a[1] !== 8'd1 || q1d[1] !== 32'hFC000000) begin
        n_err++; $display("FAIL basic_w1: got %h@%h want fc000000@01", q1d[1], q1a[1]);
      end
    end
    n_cmp++;
    if ({done1, err1, busy1, wc1} !== {3'b100, 9'd2}) begin
      n_err++; $display("FAIL basic_end: got d%b e%b b%b wc%0d want d1 e0 b0 wc2", done1, err1, busy1, wc1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4];
    words = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hFC123456};
    q1a.delete(); q1d.delete();
    pulse_start1();
    for (int w = 0; w < 4; w++) send_word1(words[w], 0);
    wait_end1();
    n_cmp++;
    if (q1a.size() !== 4) begin
      n_err++; $display("FAIL b2b_nwrites: got %0d want 4", q1a.size());
    end else begin
      for (int w = 0; w < 4; w++) begin
        n_cmp++;
        if (q1a[w] !== 8'(w) || q1d[w] !== words[w]) begin
          n_err++; $display("FAIL b2b_w%0d: got %h@%h want %h@%h", w, q1d[w], q1a[w], words[w], 8'(w));
        end
      end
    end
    n_cmp++;
    if ({done1, wc1} !== {1'b1, 9'd4}) begin
      n_err++; $display("FAIL b2b_end: got d%b wc%0d want d1 wc4", done1, wc1);
    end
  endtask

  task automatic test_error();
    pulse_start2();
    for (int w = 0; w < 4; w++) send_word2(32'h01000000 + w, 0);
    wait_end2();
    n_cmp++;
    if (q2a.size() !== 4) begin
      n_err++; $display("FAIL err_nwrites: got %0d want 4", q2a.size());
    end else begin
      for (int w = 0; w < 4; w++) begin
        n_cmp++;
        if (q2a[w] !== 2'(w) || q2d[w] !== 32'h01000000 + w) begin
          n_err++; $display("FAIL err_w%0d: got %h@%h want %h@%h", w, q2d[w], q2a[w], 32'h01000000 + w, 2'(w));
        end
      end
    end
    n_cmp++;
    if ({err2, done2, busy2, wc2} !== {3'b100, 3'd4}) begin
      n_err++; $display("FAIL err_end: got e%b d%b b%b wc%0d want e1 d0 b0 wc4", err2, done2, busy2, wc2);
    end
    send_word2(32'h02000000, 0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (q2a.size() !== 4 || wc2 !== 3'd4 || err2 !== 1'b1) begin
      n_err++; $display("FAIL err_extra: got n%0d wc%0d e%b want n4 wc4 e1", q2a.size(), wc2, err2);
    end
  endtask

  task automatic test_reset_mid();
    q1a.delete(); q1d.delete();
    pulse_start1();
    rx1 = 8'hAB; rv1 = 1'b1; @(negedge clk);
    rx1 = 8'hCD; @(negedge clk);
    rv1 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({we1, busy1, done1, err1, wc1} !== 13'h0) begin
      n_err++; $display("FAIL rstmid_outs: got %h want 0", {we1, busy1, done1, err1, wc1});
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (q1a.size() !== 0) begin
      n_err++; $display("FAIL rstmid_nowrite: got %0d want 0", q1a.size());
    end
    pulse_start1();
    send_word1(32'hFC0000AA, 0);
    wait_end1();
    n_cmp++;
    if (q1a.size() !== 1 || q1a[0] !== 8'd0 || q1d[0] !== 32'hFC0000AA) begin
      n_err++; $display("FAIL rstmid_reload: got n%0d %h want n1 fc0000aa@00", q1a.size(), q1d[0]);
    end
  endtask

  task automatic test_restart_done();
    q1a.delete(); q1d.delete();
    pulse_start1();
    n_cmp++;
    if ({done1, busy1, wc1} !== {2'b01, 9'd0}) begin
      n_err++; $display("FAIL restart_clear: got d%b b%b wc%0d want d0 b1 wc0", done1, busy1, wc1);
    end
    send_word1(32'hFC000001, 2);
    wait_end1();
    n_cmp++;
    if (q1a.size() !== 1 || q1a[0] !== 8'd0 || q1d[0] !== 32'hFC000001) begin
      n_err++; $display("FAIL restart_write: got n%0d %h want n1 fc000001@00", q1a.size(), q1d[0]);
    end
    n_cmp++;
    if ({done1, wc1} !== {1'b1, 9'd1}) begin
      n_err++; $display("FAIL restart_end: got d%b wc%0d want d1 wc1", done1, wc1);
    end
  endtask

  task automatic test_start_in_recv();
    q1a.delete(); q1d.delete();
    pulse_start1();
    rx1 = 8'h12; rv1 = 1'b1; @(negedge clk);
    rv1 = 1'b0;
    pulse_start1();
    rx1 = 8'h34; rv1 = 1'b1; @(negedge clk);
    rx1 = 8'h56; @(negedge clk);
    rx1 = 8'h78; @(negedge clk);
    rv1 = 1'b0;
    start1 = 1'b1; @(negedge clk);
    start1 = 1'b0;
    send_word1(32'hFC00BEEF, 0);
    wait_end1();
    n_cmp++;
    if (q1a.size() !== 2) begin
      n_err++; $display("FAIL sir_nwrites: got %0d want 2", q1a.size());
    end else begin
      n_cmp++;
      if (q1a[0] !== 8'd0 || q1d[0] !== 32'h12345678) begin
        n_err++; $display("FAIL sir_w0: got %h@%h want 12345678@00", q1d[0], q1a[0]);
      end
      n_cmp++;
      if (q1a[1] !== 8'd1 || q1d[1] !== 32'hFC00BEEF) begin
        n_err++; $display("FAIL sir_w1: got %h@%h want fc00beef@01", q1d[1], q1a[1]);
      end
    end
    n_cmp++;
    if ({done1, wc1} !== {1'b1, 9'd2}) begin
      n_err++; $display("FAIL sir_end: got d%b wc%0d want d1 wc2", done1, wc1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_error();
    test_reset_mid();
    test_restart_done();
    test_start_in_recv();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
